shell_cdc_rx_ctrl: RTL and testbench

Destination-side controller for a toggle-handshake clock-domain crossing. An asynchronous sender holds a multi-bit word stable and flips a request toggle. This block synchronizes the toggle through an internal multi-stage synchronizer chain, waits a settle interval, captures the word and presents it on a valid/ready interface. When the consumer accepts, it returns an acknowledge toggle to the sender. It also keeps a transfer count and a sticky protocol-error flag for shell status registers.

---
 rtl/shell_cdc_rx_ctrl.sv | 126 ++++++++++++
 tb/tb_shell_cdc_rx_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/shell_cdc_rx_ctrl.sv
// Destination side of a toggle-handshake CDC: synchronizes req_tgl, settles,
// captures din, hands it out on valid/ready and returns ack_tgl on acceptance.
module shell_cdc_rx_ctrl #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 2,
    parameter int SETTLE_CYC = 1
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             req_tgl,
    input  logic [WIDTH-1:0] din,
    output logic             ack_tgl,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             err,
    input  logic             err_clr,
    output logic [15:0]      xfer_cnt
);

    localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        VALID
    } state_e;

    // sync_q[0] is the only stage that sees the asynchronous req_tgl
    (* async_reg = "true", dont_touch = "true" *)
    logic [DEPTH-1:0] sync_q;
    logic [DEPTH-1:0] sync_d;
    logic             req_s;

    state_e           state_q, state_d;
    logic [CW-1:0]    settle_q, settle_d;
    logic             seen_q, seen_d;
    logic             ack_q, ack_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic [15:0]      xfer_cnt_q, xfer_cnt_d;

    assign req_s  = sync_q[DEPTH-1];
    assign sync_d = {sync_q[DEPTH-2:0], req_tgl};

    always_comb begin
        state_d    = state_q;
        settle_d   = settle_q;
        seen_d     = seen_q;
        ack_d      = ack_q;
        dout_d     = dout_q;
        valid_d    = valid_q;
        err_d      = err_q;
        xfer_cnt_d = xfer_cnt_q;

        // a fresh error in the same cycle as err_clr must survive
        if (err_clr) begin
            err_d = 1'b0;
        end
        if (state_q != IDLE && req_s == seen_q) begin
            err_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (req_s != seen_q) begin
                    state_d  = SETTLE;
                    settle_d = CW'(SETTLE_CYC - 1);
                end
            end
            SETTLE: begin
                if (settle_q == '0) begin
                    dout_d  = din;
                    valid_d = 1'b1;
                    state_d = VALID;
                end else begin
                    settle_d = settle_q - CW'(1);
                end
            end
            VALID: begin
                if (dout_ready) begin
                    valid_d    = 1'b0;
                    ack_d      = ~ack_q;
                    seen_d     = ~seen_q;
                    xfer_cnt_d = xfer_cnt_q + 16'd1;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            sync_q     <= '0;
            state_q    <= IDLE;
            settle_q   <= '0;
            seen_q     <= 1'b0;
            ack_q      <= 1'b0;
            dout_q     <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            xfer_cnt_q <= '0;
        end else begin
            sync_q     <= sync_d;
            state_q    <= state_d;
            settle_q   <= settle_d;
            seen_q     <= seen_d;
            ack_q      <= ack_d;
            dout_q     <= dout_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            xfer_cnt_q <= xfer_cnt_d;
        end
    end

    assign ack_tgl    = ack_q;
    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign err        = err_q;
    assign xfer_cnt   = xfer_cnt_q;

endmodule

// File: tb/tb_shell_cdc_rx_ctrl.sv
// Bench for shell_cdc_rx_ctrl: directed handshake cases, a randomized
// sender/consumer stream against a word queue, and a DEPTH=3/SETTLE=4 instance.
module tb_shell_cdc_rx_ctrl;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          arst;
    logic          req_tgl;
    logic [W-1:0]  din;
    logic          dout_ready;
    logic          err_clr;

    logic          ack_tgl, dout_valid, err;
    logic [W-1:0]  dout;
    logic [15:0]   xfer_cnt;

    logic          ack3, valid3, err3;
    logic [W-1:0]  dout3;
    logic [15:0]   xfer3;

    int checks = 0;
    int errors = 0;
    int n_xfer = 0;

    always #5 clk = ~clk;

    shell_cdc_rx_ctrl #(.WIDTH(W), .DEPTH(2), .SETTLE_CYC(1)) u_dut (
        .clk        (clk),
        .arst       (arst),
        .req_tgl    (req_tgl),
        .din        (din),
        .ack_tgl    (ack_tgl),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .err        (err),
        .err_clr    (err_clr),
        .xfer_cnt   (xfer_cnt)
    );

    shell_cdc_rx_ctrl #(.WIDTH(W), .DEPTH(3), .SETTLE_CYC(4)) u_dut3 (
        .clk        (clk),
        .arst       (arst),
        .req_tgl    (req_tgl),
        .din        (din),
        .ack_tgl    (ack3),
        .dout       (dout3),
        .dout_valid (valid3),
        .dout_ready (dout_ready),
        .err        (err3),
        .err_clr    (err_clr),
        .xfer_cnt   (xfer3)
    );

    task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic step(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_valid(string tag, int max_cyc);
        int i = 0;
        while (!dout_valid && i < max_cyc) begin
            step(1);
            i++;
        end
        chk({tag, "_seen"}, 32'(dout_valid), 32'd1);
    endtask

    // sender waits for its 2-flop-synced ack before the next toggle
    task automatic run_stream(int n, bit fixed, int ready_pct);
        logic [W-1:0] q[$];
        logic [W-1:0] hold_d = '0;
        bit   hold_v = 1'b0;
        logic a1 = ack_tgl;
        logic a2 = ack_tgl;
        int   sent = 0;
        int   got = 0;
        int   cyc = 0;
        while (got < n && cyc < 3000) begin
            if (hold_v) begin
                chk("stream_hold_v", 32'(dout_valid), 32'd1);
                chk("stream_hold_d", dout, hold_d);
            end
            if (a2 == req_tgl && sent < n) begin
                din = fixed ? W'(sent + 1) : W'($urandom);
                q.push_back(din);
                req_tgl = ~req_tgl;
                sent++;
            end
            dout_ready = int'($urandom_range(0, 99)) < ready_pct;
            if (dout_valid && dout_ready) begin
                if (q.size() == 0) begin
                    chk("stream_spurious", 32'(dout_valid), 32'd0);
                end else begin
                    chk("stream_data", dout, q.pop_front());
                end
                got++;
            end
            hold_v = dout_valid && !dout_ready;
            hold_d = dout;
            a2 = a1;
            a1 = ack_tgl;
            step(1);
            cyc++;
        end
        n_xfer += n;
        chk("stream_done", 32'(got), 32'(n));
        chk("stream_cnt", 32'(xfer_cnt), 32'(n_xfer % 65536));
        chk("stream_ack", 32'(ack_tgl), 32'(n_xfer % 2));
        chk("stream_err", 32'(err), 32'd0);
        dout_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        arst       = 1'b1;
        req_tgl    = 1'b0;
        din        = '0;
        dout_ready = 1'b0;
        err_clr    = 1'b0;
        step(2);

        chk("rst_valid", 32'(dout_valid), 32'd0);
        chk("rst_ack", 32'(ack_tgl), 32'd0);
        chk("rst_dout", dout, 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_cnt", 32'(xfer_cnt), 32'd0);
        chk("rst3_valid", 32'(valid3), 32'd0);
        chk("rst3_ack", 32'(ack3), 32'd0);
        chk("rst3_dout", dout3, 32'd0);
        chk("rst3_err", 32'(err3), 32'd0);
        chk("rst3_cnt", 32'(xfer3), 32'd0);
        arst = 1'b0;
        step(2);

        // single transfer, sampled at edge E, visible at E+3, acked at E+4
        din        = 32'hDEADBEEF;
        dout_ready = 1'b1;
        req_tgl    = 1'b1;
        step(3);
        chk("single_early", 32'(dout_valid), 32'd0);
        step(1);
        chk("single_valid", 32'(dout_valid), 32'd1);
        chk("single_dout", dout, 32'hDEADBEEF);
        chk("single_noack", 32'(ack_tgl), 32'd0);
        step(1);
        chk("single_ack", 32'(ack_tgl), 32'd1);
        chk("single_drop", 32'(dout_valid), 32'd0);
        chk("single_cnt", 32'(xfer_cnt), 32'd1);
        n_xfer = 1;

        // backpressure: word held and no ack until ready
        dout_ready = 1'b0;
        din        = 32'hA5A55A5A;
        req_tgl    = 1'b0;
        step(4);
        chk("bp_valid", 32'(dout_valid), 32'd1);
        din = W'($urandom);
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk("bp_hold_v", 32'(dout_valid), 32'd1);
            chk("bp_hold_d", dout, 32'hA5A55A5A);
            chk("bp_hold_ack", 32'(ack_tgl), 32'd1);
        end
        dout_ready = 1'b1;
        step(1);
        chk("bp_ack", 32'(ack_tgl), 32'd0);
        chk("bp_drop", 32'(dout_valid), 32'd0);
        chk("bp_cnt", 32'(xfer_cnt), 32'd2);
        n_xfer = 2;
        dout_ready = 1'b0;
        step(2);

        run_stream(4, 1'b1, 100);
        chk("b2b_ack_end", 32'(ack_tgl), 32'd0);
        run_stream(20, 1'b0, 60);
        step(2);

        // sender toggles twice before ack
        dout_ready = 1'b0;
        din        = 32'h11112222;
        req_tgl    = ~req_tgl;
        step(4);
        chk("perr_valid", 32'(dout_valid), 32'd1);
        chk("perr_noerr", 32'(err), 32'd0);
        din     = 32'h33334444;
        req_tgl = ~req_tgl;
        step(3);
        chk("perr_err", 32'(err), 32'd1);
        chk("perr_hold_v", 32'(dout_valid), 32'd1);
        chk("perr_hold_d", dout, 32'h11112222);
        dout_ready = 1'b1;
        step(1);
        n_xfer++;
        chk("perr_ack1", 32'(ack_tgl), 32'(n_xfer % 2));
        wait_valid("perr_second", 10);
        chk("perr_dout2", dout, 32'h33334444);
        step(1);
        n_xfer++;
        chk("perr_cnt", 32'(xfer_cnt), 32'(n_xfer));
        chk("perr_ack2", 32'(ack_tgl), 32'(n_xfer % 2));
        chk("perr_sticky", 32'(err), 32'd1);
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        chk("perr_clr", 32'(err), 32'd0);
        step(2);

        // reset while a word is waiting, with err raised
        dout_ready = 1'b0;
        din        = 32'h55556666;
        req_tgl    = ~req_tgl;
        step(4);
        req_tgl = ~req_tgl;
        step(3);
        chk("mrst_pre_v", 32'(dout_valid), 32'd1);
        chk("mrst_pre_err", 32'(err), 32'd1);
        arst = 1'b1;
        #1;
        chk("mrst_valid", 32'(dout_valid), 32'd0);
        chk("mrst_err", 32'(err), 32'd0);
        chk("mrst_cnt", 32'(xfer_cnt), 32'd0);
        chk("mrst_ack", 32'(ack_tgl), 32'd0);
        n_xfer  = 0;
        req_tgl = 1'b0;
        step(2);
        arst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            chk("mrst_quiet", 32'(dout_valid), 32'd0);
        end
        chk("mrst_cnt2", 32'(xfer_cnt), 32'd0);

        // counter wrap on the default instance
        u_dut.xfer_cnt_q <= 16'hFFFF;
        step(1);
        chk("wrap_preload", 32'(xfer_cnt), 32'hFFFF);

        // both instances see the same request; latency E+3 vs E+7
        dout_ready = 1'b1;
        din        = 32'hCAFEF00D;
        req_tgl    = 1'b1;
        step(4);
        chk("wrap_valid", 32'(dout_valid), 32'd1);
        step(1);
        chk("wrap_cnt", 32'(xfer_cnt), 32'h0000);
        chk("wrap_ack", 32'(ack_tgl), 32'd1);
        step(2);
        chk("sweep_early", 32'(valid3), 32'd0);
        step(1);
        chk("sweep_valid", 32'(valid3), 32'd1);
        chk("sweep_dout", dout3, 32'hCAFEF00D);
        step(1);
        chk("sweep_drop", 32'(valid3), 32'd0);
        chk("sweep_ack", 32'(ack3), 32'd1);
        chk("sweep_cnt", 32'(xfer3), 32'd1);
        dout_ready = 1'b0;
        step(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
